// File: rtl/cpu_multicycle.sv
// cpu_multicycle -- multi-cycle RV32I-subset core.
// A control FSM sequences a decoder, register file and ALU over one shared
// req/ack memory port. Instruction fetches and data accesses both use this
// port, so memories with any latency are supported. The core halts on an
// unsupported opcode or funct field.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   mem_req/mem_we      bus request (held until acked) / write strobe (SW)
//   mem_addr/mem_wdata  word-aligned byte address / store data
//   mem_rdata/mem_ack   read data / handshake; a transfer completes on the
//                       edge where mem_req && mem_ack
//   zero                registered ALU zero flag from the last EXEC
//   halted              core is parked in HALT
//   dbg_ra/dbg_rd       combinational debug read port of the register file
//   cycle_cnt           cycle counter (optional)
//   retire_cnt          retired-instruction counter (optional)
//
// Optional feature: define CPU_PERF_CNT_EN to build the two counters.
// When the macro is undefined, both counter ports read 0 and no counter
// flops are built.
module cpu_multicycle #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic [XLEN-1:0]         mem_rdata,
    input  logic                    mem_ack,
    output logic                    zero,
    output logic                    halted,
    input  logic [$clog2(NREG)-1:0] dbg_ra,
    output logic [XLEN-1:0]         dbg_rd,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             retire_cnt
);
    localparam int unsigned     RB      = $clog2(NREG);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
        OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_ADDI = 4'd6,  OP_LW   = 4'd7,
        OP_SW   = 4'd8,  OP_BEQ  = 4'd9,  OP_BNE  = 4'd10, OP_JAL  = 4'd11,
        OP_LUI  = 4'd12, OP_ILL  = 4'd15
    } op_t;

    state_t          state_r, state_nx_s;
    op_t             op_s;
    logic [31:0]     ir_r;
    logic [XLEN-1:0] pc_r, a_r, b_r, aluout_r, mdr_r;
    logic            zero_r;
    logic [XLEN-1:0] rf_r [NREG];

    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [XLEN-1:0] alu_s, wb_data_s;
    logic [RB-1:0]   rd_s, rs1_s, rs2_s;
    logic            taken_s;

    // Register indices: bits above log2(NREG) are dropped (index modulo NREG)
    assign rd_s  = ir_r[7  +: RB];
    assign rs1_s = ir_r[15 +: RB];
    assign rs2_s = ir_r[20 +: RB];

    // Sign-extended immediates for every instruction format
    assign imm_i_s = {{(XLEN-12){ir_r[31]}}, ir_r[31:20]};
    assign imm_s_s = {{(XLEN-12){ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
    assign imm_b_s = {{(XLEN-13){ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
    assign imm_u_s = {{(XLEN-20){ir_r[31]}}, ir_r[31:12]};
    assign imm_j_s = {{(XLEN-21){ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};

    // Instruction decode: classify IR, anything unsupported becomes OP_ILL
    always_comb begin
        op_s = OP_ILL;
        case (ir_r[6:0])
            7'b0110011: begin
                case ({ir_r[31:25], ir_r[14:12]})
                    10'b0000000_000: op_s = OP_ADD;
                    10'b0100000_000: op_s = OP_SUB;
                    10'b0000000_111: op_s = OP_AND;
                    10'b0000000_110: op_s = OP_OR;
                    10'b0000000_100: op_s = OP_XOR;
                    10'b0000000_010: op_s = OP_SLT;
                    default:         op_s = OP_ILL;
                endcase
            end
            7'b0010011: op_s = (ir_r[14:12] == 3'b000) ? OP_ADDI : OP_ILL;
            7'b0000011: op_s = (ir_r[14:12] == 3'b010) ? OP_LW   : OP_ILL;
            7'b0100011: op_s = (ir_r[14:12] == 3'b010) ? OP_SW   : OP_ILL;
            7'b1100011: begin
                case (ir_r[14:12])
                    3'b000:  op_s = OP_BEQ;
                    3'b001:  op_s = OP_BNE;
                    default: op_s = OP_ILL;
                endcase
            end
            7'b1101111: op_s = OP_JAL;
            7'b0110111: op_s = OP_LUI;
            default:    op_s = OP_ILL;
        endcase
    end

    // ALU: branches subtract so that zero reflects rs1 == rs2
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (op_s)
            OP_ADD:  alu_s = a_r + b_r;
            OP_SUB:  alu_s = a_r - b_r;
            OP_AND:  alu_s = a_r & b_r;
            OP_OR:   alu_s = a_r | b_r;
            OP_XOR:  alu_s = a_r ^ b_r;
            OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
            OP_ADDI: alu_s = a_r + imm_i_s;
            OP_LW:   alu_s = a_r + imm_i_s;
            OP_SW:   alu_s = a_r + imm_s_s;
            OP_BEQ:  alu_s = a_r - b_r;
            OP_BNE:  alu_s = a_r - b_r;
            OP_JAL:  alu_s = pc_r + PC_STEP;
            OP_LUI:  alu_s = {imm_u_s[XLEN-13:0], 12'h000};
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    assign taken_s   = (op_s == OP_BEQ) ? (a_r == b_r) : (a_r != b_r);
    assign wb_data_s = (op_s == OP_LW) ? mdr_r : aluout_r;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; mem_ack is only looked at in FETCH and MEM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_FETCH:  state_nx_s = mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: state_nx_s = (op_s == OP_ILL) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
                    OP_ADDI, OP_JAL, OP_LUI: state_nx_s = S_WB;
                    OP_LW, OP_SW:            state_nx_s = S_MEM;
                    OP_BEQ, OP_BNE:          state_nx_s = S_FETCH;
                    default:                 state_nx_s = S_HALT;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_nx_s = (op_s == OP_LW) ? S_WB : S_FETCH;
                end else begin
                    state_nx_s = S_MEM;
                end
            end
            S_WB:    state_nx_s = S_FETCH;
            S_HALT:  state_nx_s = S_HALT;
            default: state_nx_s = S_HALT;
        endcase
    end

    // Bus and status outputs; rst gates the bus off without waiting for an edge
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {pc_r[XLEN-1:2], 2'b00};
        mem_wdata = {XLEN{1'b0}};
        halted    = 1'b0;
        if (rst) begin
            mem_req = 1'b0;
        end else begin
            case (state_r)
                S_FETCH: mem_req = 1'b1;
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = {aluout_r[XLEN-1:2], 2'b00};
                    if (op_s == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = b_r;
                    end else begin
                        mem_we    = 1'b0;
                    end
                end
                S_HALT:  halted = 1'b1;
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign zero = zero_r;

    // Datapath registers: IR, operand latches, ALUOUT, MDR, PC, zero flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r     <= 32'h0000_0000;
            pc_r     <= RESET_PC;
            a_r      <= {XLEN{1'b0}};
            b_r      <= {XLEN{1'b0}};
            aluout_r <= {XLEN{1'b0}};
            mdr_r    <= {XLEN{1'b0}};
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (mem_ack) ir_r <= mem_rdata[31:0];
                end
                S_DECODE: begin
                    a_r <= rf_r[rs1_s];
                    b_r <= rf_r[rs2_s];
                end
                S_EXEC: begin
                    aluout_r <= alu_s;
                    zero_r   <= (alu_s == {XLEN{1'b0}});
                    if (op_s == OP_BEQ || op_s == OP_BNE) begin
                        pc_r <= taken_s ? (pc_r + imm_b_s) : (pc_r + PC_STEP);
                    end else if (op_s == OP_JAL) begin
                        pc_r <= pc_r + imm_j_s;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op_s == OP_LW) mdr_r <= mem_rdata;
                        else               pc_r  <= pc_r + PC_STEP;
                    end
                end
                S_WB: begin
                    // JAL already redirected the PC in EXEC
                    if (op_s != OP_JAL) pc_r <= pc_r + PC_STEP;
                end
                default: pc_r <= pc_r;
            endcase
        end
    end

    // Register file; x0 is never written so it always reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) rf_r[i] <= {XLEN{1'b0}};
        end else if (state_r == S_WB && rd_s != {RB{1'b0}}) begin
            rf_r[rd_s] <= wb_data_s;
        end
    end

    assign dbg_rd = (dbg_ra == {RB{1'b0}}) ? {XLEN{1'b0}} : rf_r[dbg_ra];

`ifdef CPU_PERF_CNT_EN
    logic [31:0] cycle_cnt_r, retire_cnt_r;
    logic        retire_evt_s;

    // An instruction retires when control returns to FETCH from EXEC/MEM/WB
    assign retire_evt_s = (state_r == S_EXEC || state_r == S_MEM || state_r == S_WB)
                          && (state_nx_s == S_FETCH);

    // Performance counters, frozen in HALT; the cycle counter saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_r  <= 32'd0;
            retire_cnt_r <= 32'd0;
        end else if (state_r != S_HALT) begin
            if (cycle_cnt_r != 32'hFFFF_FFFF) cycle_cnt_r <= cycle_cnt_r + 32'd1;
            if (retire_evt_s)                 retire_cnt_r <= retire_cnt_r + 32'd1;
        end
    end

    assign cycle_cnt  = cycle_cnt_r;
    assign retire_cnt = retire_cnt_r;
`else
    assign cycle_cnt  = 32'd0;
    assign retire_cnt = 32'd0;
`endif

endmodule
